// File: rtl/math_pkg.sv
// Shared math library helpers: pipeline depth and two's-complement utilities
// used by the pipeline divider and the multi-operand pipeline adder.
package math_pkg;

    localparam int MATH_MAX_WIDTH = 64;

    // Input register + one restoring step per quotient bit + output register.
    function automatic int pipeline_divider_stages(input int dividend_width);
        return dividend_width + 2;
    endfunction

    // Two's-complement negation on a sign/zero-extended operand.
    function automatic logic [MATH_MAX_WIDTH-1:0] neg(input logic [MATH_MAX_WIDTH-1:0] value);
        return ~value + 64'd1;
    endfunction

    // Magnitude of a sign-extended operand; the most negative value of the
    // caller's width comes back as its unsigned magnitude once truncated.
    function automatic logic [MATH_MAX_WIDTH-1:0] abs_val(input logic [MATH_MAX_WIDTH-1:0] value);
        return value[MATH_MAX_WIDTH-1] ? neg(value) : value;
    endfunction

endpackage

// File: rtl/pipeline_divider_stage.sv
// One registered restoring-division step. The dividend bits and the growing
// quotient share one shift register: the dividend MSB leaves on the left
// into the partial remainder while the new quotient bit enters on the right.
module pipeline_divider_stage
    import math_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      valid_i,
    input  logic [DIVISOR_WIDTH:0]    rem_i,
    input  logic [DIVIDEND_WIDTH-1:0] dq_i,
    input  logic [DIVISOR_WIDTH-1:0]  dsr_i,
    input  logic                      q_neg_i,
    input  logic                      r_neg_i,
    input  logic                      dbz_i,
    output logic                      valid_o,
    output logic [DIVISOR_WIDTH:0]    rem_o,
    output logic [DIVIDEND_WIDTH-1:0] dq_o,
    output logic [DIVISOR_WIDTH-1:0]  dsr_o,
    output logic                      q_neg_o,
    output logic                      r_neg_o,
    output logic                      dbz_o
);

    logic                      valid_q, valid_d;
    logic [DIVISOR_WIDTH:0]    rem_q, rem_d;
    logic [DIVIDEND_WIDTH-1:0] dq_q, dq_d;
    logic [DIVISOR_WIDTH-1:0]  dsr_q, dsr_d;
    logic                      q_neg_q, q_neg_d;
    logic                      r_neg_q, r_neg_d;
    logic                      dbz_q, dbz_d;

    logic [DIVISOR_WIDTH:0]    trial_rem;
    logic                      trial_ge;
    logic [DIVISOR_WIDTH:0]    step_rem;

    // The remainder MSB shifted out here is always zero for a nonzero divisor;
    // with a zero divisor only the low bits of the raw dividend are kept.
    logic                      unused_rem_msb;
    assign unused_rem_msb = rem_i[DIVISOR_WIDTH];

    // Shift in the next dividend bit, trial-subtract, and advance only when enabled.
    always_comb begin
        trial_rem = {rem_i[DIVISOR_WIDTH-1:0], dq_i[DIVIDEND_WIDTH-1]};
        trial_ge  = (trial_rem >= {1'b0, dsr_i});
        step_rem  = trial_ge ? (trial_rem - {1'b0, dsr_i}) : trial_rem;

        valid_d = valid_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        dsr_d   = dsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dbz_d   = dbz_q;
        if (en_i) begin
            valid_d = valid_i;
            rem_d   = step_rem;
            dq_d    = {dq_i[DIVIDEND_WIDTH-2:0], trial_ge};
            dsr_d   = dsr_i;
            q_neg_d = q_neg_i;
            r_neg_d = r_neg_i;
            dbz_d   = dbz_i;
        end
    end

    // Stage state register, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            rem_q   <= '0;
            dq_q    <= '0;
            dsr_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dsr_q   <= dsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dbz_q   <= dbz_d;
        end
    end

    assign valid_o = valid_q;
    assign rem_o   = rem_q;
    assign dq_o    = dq_q;
    assign dsr_o   = dsr_q;
    assign q_neg_o = q_neg_q;
    assign r_neg_o = r_neg_q;
    assign dbz_o   = dbz_q;

endmodule

// File: rtl/pipeline_divider.sv
// Fully pipelined integer divider: input/magnitude stage, one restoring step
// per quotient bit, then sign correction into the output register. All stages
// share one advance enable driven by the output handshake.
module pipeline_divider
    import math_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8,
    parameter bit SIGNED         = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
    input  logic                      data_valid_i,
    output logic                      ready_o,
    output logic [DIVIDEND_WIDTH-1:0] quotient_o,
    output logic [DIVISOR_WIDTH-1:0]  remainder_o,
    output logic                      div_by_zero_o,
    output logic                      data_valid_o,
    input  logic                      ready_i
);

    localparam int DW     = DIVIDEND_WIDTH;
    localparam int SW     = DIVISOR_WIDTH;
    localparam int STAGES = pipeline_divider_stages(DIVIDEND_WIDTH);
    localparam int STEPS  = STAGES - 2;

    logic          in_valid_q, in_valid_d;
    logic [DW-1:0] in_dvd_q, in_dvd_d;
    logic [SW-1:0] in_dsr_q, in_dsr_d;
    logic          in_q_neg_q, in_q_neg_d;
    logic          in_r_neg_q, in_r_neg_d;
    logic          in_dbz_q, in_dbz_d;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_quot_q, out_quot_d;
    logic [SW-1:0] out_rem_q, out_rem_d;
    logic          out_dbz_q, out_dbz_d;

    logic          dsr_zero, dvd_neg, dsr_neg;
    logic [DW-1:0] dvd_mag, q_fin;
    logic [SW-1:0] dsr_mag, r_fin;

    logic          valid_w [STEPS+1];
    logic [SW:0]   rem_w   [STEPS+1];
    logic [DW-1:0] dq_w    [STEPS+1];
    logic [SW-1:0] dsr_w   [STEPS+1];
    logic          q_neg_w [STEPS+1];
    logic          r_neg_w [STEPS+1];
    logic          dbz_w   [STEPS+1];

    logic          unused_tail;

    assign ready_o = !out_valid_q || ready_i;

    // Input stage: take magnitudes and sign flags; a zero divisor keeps the raw
    // dividend so the steps naturally yield all-ones and its low bits.
    always_comb begin
        dsr_zero = (divisor_i == '0);
        dvd_neg  = 1'b0;
        dsr_neg  = 1'b0;
        dvd_mag  = dividend_i;
        dsr_mag  = divisor_i;
        if (SIGNED) begin
            dvd_neg = dividend_i[DW-1];
            dsr_neg = divisor_i[SW-1];
            dvd_mag = DW'(abs_val({{(MATH_MAX_WIDTH-DW){dividend_i[DW-1]}}, dividend_i}));
            dsr_mag = SW'(abs_val({{(MATH_MAX_WIDTH-SW){divisor_i[SW-1]}}, divisor_i}));
        end

        in_valid_d = in_valid_q;
        in_dvd_d   = in_dvd_q;
        in_dsr_d   = in_dsr_q;
        in_q_neg_d = in_q_neg_q;
        in_r_neg_d = in_r_neg_q;
        in_dbz_d   = in_dbz_q;
        if (ready_o) begin
            in_valid_d = data_valid_i;
            in_dvd_d   = dsr_zero ? dividend_i : dvd_mag;
            in_dsr_d   = dsr_mag;
            in_q_neg_d = !dsr_zero && (dvd_neg ^ dsr_neg);
            in_r_neg_d = !dsr_zero && dvd_neg;
            in_dbz_d   = dsr_zero;
        end
    end

    // Input stage register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_valid_q <= 1'b0;
            in_dvd_q   <= '0;
            in_dsr_q   <= '0;
            in_q_neg_q <= 1'b0;
            in_r_neg_q <= 1'b0;
            in_dbz_q   <= 1'b0;
        end else begin
            in_valid_q <= in_valid_d;
            in_dvd_q   <= in_dvd_d;
            in_dsr_q   <= in_dsr_d;
            in_q_neg_q <= in_q_neg_d;
            in_r_neg_q <= in_r_neg_d;
            in_dbz_q   <= in_dbz_d;
        end
    end

    assign valid_w[0] = in_valid_q;
    assign rem_w[0]   = '0;
    assign dq_w[0]    = in_dvd_q;
    assign dsr_w[0]   = in_dsr_q;
    assign q_neg_w[0] = in_q_neg_q;
    assign r_neg_w[0] = in_r_neg_q;
    assign dbz_w[0]   = in_dbz_q;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        pipeline_divider_stage #(
            .DIVIDEND_WIDTH(DW),
            .DIVISOR_WIDTH (SW)
        ) u_stage (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (ready_o),
            .valid_i(valid_w[i]),
            .rem_i  (rem_w[i]),
            .dq_i   (dq_w[i]),
            .dsr_i  (dsr_w[i]),
            .q_neg_i(q_neg_w[i]),
            .r_neg_i(r_neg_w[i]),
            .dbz_i  (dbz_w[i]),
            .valid_o(valid_w[i+1]),
            .rem_o  (rem_w[i+1]),
            .dq_o   (dq_w[i+1]),
            .dsr_o  (dsr_w[i+1]),
            .q_neg_o(q_neg_w[i+1]),
            .r_neg_o(r_neg_w[i+1]),
            .dbz_o  (dbz_w[i+1])
        );
    end

    // The divisor and the remainder guard bit are not needed past the last step.
    assign unused_tail = ^{dsr_w[STEPS], rem_w[STEPS][SW]};

    // Output stage: reapply signs to the magnitudes (flags are clear for a zero divisor).
    always_comb begin
        q_fin = dq_w[STEPS];
        r_fin = rem_w[STEPS][SW-1:0];
        if (q_neg_w[STEPS]) begin
            q_fin = DW'(neg({{(MATH_MAX_WIDTH-DW){1'b0}}, dq_w[STEPS]}));
        end
        if (r_neg_w[STEPS]) begin
            r_fin = SW'(neg({{(MATH_MAX_WIDTH-SW){1'b0}}, rem_w[STEPS][SW-1:0]}));
        end

        out_valid_d = out_valid_q;
        out_quot_d  = out_quot_q;
        out_rem_d   = out_rem_q;
        out_dbz_d   = out_dbz_q;
        if (ready_o) begin
            out_valid_d = valid_w[STEPS];
            out_quot_d  = q_fin;
            out_rem_d   = r_fin;
            out_dbz_d   = dbz_w[STEPS];
        end
    end

    // Output register; holds its contents while downstream stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_quot_q  <= '0;
            out_rem_q   <= '0;
            out_dbz_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_quot_q  <= out_quot_d;
            out_rem_q   <= out_rem_d;
            out_dbz_q   <= out_dbz_d;
        end
    end

    assign data_valid_o  = out_valid_q;
    assign quotient_o    = out_quot_q;
    assign remainder_o   = out_rem_q;
    assign div_by_zero_o = out_dbz_q;

endmodule
